// File: rtl/ex_result_stage_if.sv
// EX -> result-stage bundle: EX handshake and ALU results in; EX/MEM payload,
// fetch redirect, trap handshake and taken-branch count out.
interface ex_result_stage_if #(
  parameter int unsigned DSize = 32,
  parameter int unsigned CSize = 16
);
  logic             ex_valid;
  logic             ex_ready;
  logic [3:0]       ex_op;
  logic [DSize-1:0] alu_result;
  logic             overflow;
  logic             branch_true;
  logic [DSize-1:0] ex_pc;
  logic [DSize-1:0] branch_target;
  logic [4:0]       ex_rd;

  logic             mem_valid;
  logic [DSize-1:0] mem_result;
  logic [4:0]       mem_rd;
  logic             mem_wen;
  logic             mem_ready;

  logic             redirect_valid;
  logic [DSize-1:0] redirect_pc;

  logic             trap;
  logic [DSize-1:0] trap_pc;
  logic             trap_ack;

  logic [CSize-1:0] taken_cnt;

  // Result stage side
  modport slave (
    input  ex_valid, ex_op, alu_result, overflow, branch_true, ex_pc,
           branch_target, ex_rd, mem_ready, trap_ack,
    output ex_ready, mem_valid, mem_result, mem_rd, mem_wen,
           redirect_valid, redirect_pc, trap, trap_pc, taken_cnt
  );

  // Surrounding pipeline side
  modport master (
    output ex_valid, ex_op, alu_result, overflow, branch_true, ex_pc,
           branch_target, ex_rd, mem_ready, trap_ack,
    input  ex_ready, mem_valid, mem_result, mem_rd, mem_wen,
           redirect_valid, redirect_pc, trap, trap_pc, taken_cnt
  );
endinterface

// File: rtl/ex_result_stage.sv
// EX result stage: registers the EX result into the EX/MEM slot, raises a
// one-cycle fetch redirect for taken branches/jumps, and parks the pipe on
// an arithmetic overflow trap until software acknowledges it.
module ex_result_stage #(
  parameter int unsigned DSize = 32,
  parameter int unsigned CSize = 16
) (
  input  logic             clk,
  input  logic             rst,
  ex_result_stage_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    TRAP,
    WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_mem_valid;
  logic [DSize-1:0] r_mem_result;
  logic [4:0]       r_mem_rd;
  logic             r_mem_wen;
  logic             r_redirect_valid;
  logic [DSize-1:0] r_redirect_pc;
  logic [DSize-1:0] r_trap_pc;
  logic [CSize-1:0] r_taken_cnt;

  logic             w_is_branch;
  logic             w_ovf_op;
  logic             w_wen_op;
  logic             w_ex_ready;
  logic             w_accept;
  logic             w_fault;
  logic             w_take;
  logic             w_trap;

  // Opcode classification and the EX acceptance handshake
  always_comb begin
    w_is_branch = (bus.ex_op >= 4'b1011);
    w_ovf_op    = (bus.ex_op == 4'b0000) || (bus.ex_op == 4'b0001);
    w_wen_op    = (bus.ex_op <= 4'b0111) || (bus.ex_op == 4'b1001) ||
                  (bus.ex_op == 4'b1010);
    w_ex_ready  = !rst && (r_state == RUN) && !r_redirect_valid &&
                  (!r_mem_valid || bus.mem_ready);
    w_accept    = bus.ex_valid && w_ex_ready;
    w_fault     = w_accept && w_ovf_op && bus.overflow;
    w_take      = w_accept && w_is_branch && bus.branch_true;
  end

  // Trap FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Trap FSM next state and trap strobe; trap_ack only matters in WAIT
  always_comb begin
    w_state_nxt = r_state;
    w_trap      = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_fault) w_state_nxt = TRAP;
      end
      TRAP: begin
        w_trap      = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.trap_ack) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // EX/MEM payload: load on accept, drop valid once MEM consumes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_valid  <= 1'b0;
      r_mem_result <= '0;
      r_mem_rd     <= '0;
      r_mem_wen    <= 1'b0;
    end else if (w_accept) begin
      r_mem_valid  <= 1'b1;
      r_mem_result <= bus.alu_result;
      r_mem_rd     <= bus.ex_rd;
      r_mem_wen    <= w_wen_op && (bus.ex_rd != '0) && !w_fault;
    end else if (r_mem_valid && bus.mem_ready) begin
      r_mem_valid  <= 1'b0;
      r_mem_wen    <= 1'b0;
    end
  end

  // One-cycle redirect pulse for a taken branch/jump; target held afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_take;
      if (w_take) r_redirect_pc <= bus.branch_target;
    end
  end

  // Faulting PC captured at acceptance and held until the next trap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trap_pc <= '0;
    end else if (w_fault) begin
      r_trap_pc <= bus.ex_pc;
    end
  end

  // Saturating taken-branch counter, advanced together with each redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken_cnt <= '0;
    end else if (w_take && (r_taken_cnt != '1)) begin
      r_taken_cnt <= r_taken_cnt + CSize'(1);
    end
  end

  assign bus.ex_ready       = w_ex_ready;
  assign bus.mem_valid      = r_mem_valid;
  assign bus.mem_result     = r_mem_result;
  assign bus.mem_rd         = r_mem_rd;
  assign bus.mem_wen        = r_mem_wen;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.trap           = w_trap;
  assign bus.trap_pc        = r_trap_pc;
  assign bus.taken_cnt      = r_taken_cnt;

endmodule
